serial_config_receiver: RTL

//  Target-side end of the p_sck/p_sda/p_scapt/p_reset configuration link driven by the SerialConfig shifter.

---
 rtl/serial_config_receiver.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/serial_config_receiver.sv
// Target-side receiver for the p_sck/p_sda/p_scapt/p_reset configuration link.
// Oversamples the serial lines, deserialises one frame and commits it to cfg_data on capture.
module serial_config_receiver #(
  parameter int unsigned NUM_REGS    = 13,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [8*NUM_REGS-1:0] RESET_CFG = '0
) (
  input  logic                                 clkin,
  input  logic                                 rst_n,
  input  logic                                 p_sck,
  input  logic                                 p_sda,
  input  logic                                 p_scapt,
  input  logic                                 p_reset,
  output logic [8*NUM_REGS-1:0]                cfg_data,
  output logic                                 cfg_valid,
  output logic                                 frame_err,
  output logic [$clog2(8*NUM_REGS+1)-1:0]      bit_count,
  output logic                                 busy
);

  localparam int unsigned FRAME_BITS = 8 * NUM_REGS;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int unsigned LINES      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0][LINES-1:0] sync_q;
  logic [1:0]                        hist_q;
  logic [LINES-1:0]                  sync_w;
  logic                              sck_rise;
  logic                              scapt_rise;
  logic                              sda_w;
  logic                              link_rst;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        bit_count_q, bit_count_d;
  logic [FRAME_BITS-1:0]   sr_q, sr_d;
  logic                    frame_err_q, frame_err_d;
  logic                    commit_q, commit_d;
  logic                    busy_q, busy_d;
  logic [FRAME_BITS-1:0]   cfg_data_q;
  logic                    cfg_valid_q;

  // Shift order puts myReg1 in the top byte; committed layout wants it in byte 0.
  function automatic logic [FRAME_BITS-1:0] reverse_bytes(input logic [FRAME_BITS-1:0] v);
    logic [FRAME_BITS-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      r[8*k +: 8] = v[8*(NUM_REGS-1-k) +: 8];
    end
    return r;
  endfunction

  // Line order in the synchroniser: {p_reset, p_scapt, p_sda, p_sck}.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {p_reset, p_scapt, p_sda, p_sck}};
      hist_q <= {sync_w[2], sync_w[0]};
    end
  end

  assign sync_w     = sync_q[SYNC_STAGES-1];
  assign sck_rise   = sync_w[0] & ~hist_q[0];
  assign sda_w      = sync_w[1];
  assign scapt_rise = sync_w[2] & ~hist_q[1];
  assign link_rst   = sync_w[3];

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_count_q <= '0;
      sr_q        <= '0;
      frame_err_q <= 1'b0;
      commit_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
      sr_q        <= sr_d;
      frame_err_q <= frame_err_d;
      commit_q    <= commit_d;
      busy_q      <= busy_d;
    end
  end

  // Priority: link reset level, then capture edge, then serial clock edge.
  always_comb begin
    state_d     = state_q;
    bit_count_d = bit_count_q;
    sr_d        = sr_q;
    frame_err_d = frame_err_q;
    commit_d    = 1'b0;

    if (link_rst) begin
      state_d     = IDLE;
      bit_count_d = '0;
      sr_d        = '0;
      frame_err_d = 1'b0;
    end else if (scapt_rise) begin
      if (sck_rise) begin
        frame_err_d = 1'b1;
      end
      if (state_q == FULL) begin
        commit_d = 1'b1;
      end else begin
        frame_err_d = 1'b1;
      end
      state_d     = IDLE;
      bit_count_d = '0;
    end else if (sck_rise) begin
      case (state_q)
        IDLE, SHIFT: begin
          sr_d        = {sr_q[FRAME_BITS-2:0], sda_w};
          bit_count_d = bit_count_q + CNT_W'(1);
          state_d     = (bit_count_q == CNT_W'(FRAME_BITS - 1)) ? FULL : SHIFT;
        end
        FULL: begin
          frame_err_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // Commit lands one cycle after the capture edge is acted on.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      cfg_data_q  <= RESET_CFG;
      cfg_valid_q <= 1'b0;
    end else begin
      cfg_valid_q <= commit_q;
      if (commit_q) begin
        cfg_data_q <= reverse_bytes(sr_q);
      end
    end
  end

  assign cfg_data  = cfg_data_q;
  assign cfg_valid = cfg_valid_q;
  assign frame_err = frame_err_q;
  assign bit_count = bit_count_q;
  assign busy      = busy_q;

endmodule
